// File: rtl/ingress_buffer.sv
// ingress_buffer: single-packet store-and-forward ingress buffer feeding an SRAM chain manager.
// Define INGRESS_TIMEOUT_EN to abandon a packet whose grant does not arrive within TIMEOUT cycles.
module ingress_buffer #(
   parameter int unsigned MAX_WORDS = 255,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic [63:0] in_data,
   output logic        in_ready,
   output logic        wea,
   output logic [7:0]  w_size,
   output logic [2:0]  pkt_priority,
   output logic [3:0]  dest_port,
   input  logic        writing,
   input  logic [11:0] write_address,
   output logic        sram_we,
   output logic [11:0] sram_addr,
   output logic [63:0] sram_din,
   output logic        pkt_drop,
   output logic        busy
);

   localparam int unsigned IDX_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [7:0]  MAX_LEN  = 8'(MAX_WORDS);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
`ifdef INGRESS_TIMEOUT_EN
   localparam bit          TMO_EN   = 1'b1;
`else
   localparam bit          TMO_EN   = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RECV = 3'd1,
      S_REQ  = 3'd2,
      S_WAIT = 3'd3,
      S_XFER = 3'd4,
      S_DROP = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  rd_idx_q, rd_idx_d;
   logic [7:0]  len_q, len_d;
   logic [2:0]  pri_q, pri_d;
   logic [3:0]  dest_q, dest_d;
   logic [15:0] tmo_q, tmo_d;

   logic        in_ready_q;
   logic        busy_q;
   logic        wea_q;
   logic [7:0]  w_size_q;
   logic [2:0]  pri_out_q;
   logic [3:0]  dest_out_q;
   logic        sram_we_q;
   logic [11:0] sram_addr_q;
   logic [63:0] sram_din_q;
   logic        pkt_drop_q;

   logic             wea_d;
   logic             drop_d;
   logic             we_d;
   logic             accept_s;
   logic             buf_we_s;
   logic [IDX_W-1:0] buf_widx_s;

   logic [63:0] pkt_buf_q [0:MAX_WORDS-1];

   assign accept_s = in_valid && in_ready_q;

   // Next-state, counter and pulse decode for the packet FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_idx_d   = rd_idx_q;
      len_d      = len_q;
      pri_d      = pri_q;
      dest_d     = dest_q;
      tmo_d      = tmo_q;
      wea_d      = 1'b0;
      drop_d     = 1'b0;
      we_d       = 1'b0;
      buf_we_s   = 1'b0;
      buf_widx_s = {IDX_W{1'b0}};
      case (state_q)
         S_IDLE, S_RECV: begin
            if (accept_s && in_sop) begin
               // A new SOP always restarts reception; mid-packet it discards the old one.
               buf_we_s = 1'b1;
               pri_d    = in_data[6:4];
               dest_d   = in_data[3:0];
               cnt_d    = 8'd1;
               rd_idx_d = 8'd0;
               drop_d   = (state_q == S_RECV);
               if (in_eop) begin
                  state_d = S_REQ;
                  wea_d   = 1'b1;
                  len_d   = 8'd1;
               end else if (MAX_LEN == 8'd1) begin
                  state_d = S_DROP;
                  drop_d  = 1'b1;
               end else begin
                  state_d = S_RECV;
               end
            end else if (accept_s && (state_q == S_RECV)) begin
               buf_we_s   = 1'b1;
               buf_widx_s = cnt_q[IDX_W-1:0];
               cnt_d      = cnt_q + 8'd1;
               if (in_eop) begin
                  state_d = S_REQ;
                  wea_d   = 1'b1;
                  len_d   = cnt_q + 8'd1;
               end else if ((cnt_q + 8'd1) == MAX_LEN) begin
                  state_d = S_DROP;
                  drop_d  = 1'b1;
               end else begin
                  state_d = S_RECV;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
            tmo_d   = 16'd0;
         end
         S_WAIT, S_XFER: begin
            if (writing) begin
               we_d     = 1'b1;
               rd_idx_d = rd_idx_q + 8'd1;
               if ((rd_idx_q + 8'd1) == len_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_XFER;
               end
            end else if (state_q == S_XFER) begin
               drop_d  = 1'b1;
               state_d = S_IDLE;
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               drop_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_DROP: begin
            if (accept_s && in_eop) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DROP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Packet storage; contents are don't-care after reset so no reset term.
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         pkt_buf_q[buf_widx_s] <= in_data;
      end
   end

   // FSM state, counters and every registered output.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         rd_idx_q    <= 8'd0;
         len_q       <= 8'd0;
         pri_q       <= 3'd0;
         dest_q      <= 4'd0;
         tmo_q       <= 16'd0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         wea_q       <= 1'b0;
         w_size_q    <= 8'd0;
         pri_out_q   <= 3'd0;
         dest_out_q  <= 4'd0;
         sram_we_q   <= 1'b0;
         sram_addr_q <= 12'd0;
         sram_din_q  <= 64'd0;
         pkt_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_idx_q    <= rd_idx_d;
         len_q       <= len_d;
         pri_q       <= pri_d;
         dest_q      <= dest_d;
         tmo_q       <= tmo_d;
         in_ready_q  <= (state_d == S_IDLE) || (state_d == S_RECV) || (state_d == S_DROP);
         busy_q      <= (state_d != S_IDLE);
         wea_q       <= wea_d;
         w_size_q    <= wea_d ? len_d : 8'd0;
         pri_out_q   <= wea_d ? pri_d : 3'd0;
         dest_out_q  <= wea_d ? dest_d : 4'd0;
         sram_we_q   <= we_d;
         sram_addr_q <= we_d ? write_address : 12'd0;
         sram_din_q  <= we_d ? pkt_buf_q[rd_idx_q[IDX_W-1:0]] : 64'd0;
         pkt_drop_q  <= drop_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign wea          = wea_q;
   assign w_size       = w_size_q;
   assign pkt_priority = pri_out_q;
   assign dest_port    = dest_out_q;
   assign sram_we      = sram_we_q;
   assign sram_addr    = sram_addr_q;
   assign sram_din     = sram_din_q;
   assign pkt_drop     = pkt_drop_q;

endmodule

// File: tb/tb_ingress_buffer.sv
// Directed bench for ingress_buffer: stimulus pushes expected allocations and SRAM
// writes into queues that a negedge monitor pops and compares.
module tb_ingress_buffer;

   localparam int MAXW = 8;
   localparam int TMO  = 16;
   localparam int EXP_WEA = 8;
`ifdef INGRESS_TIMEOUT_EN
   localparam int EXP_WE   = 23;
   localparam int EXP_DROP = 4;
`else
   localparam int EXP_WE   = 25;
   localparam int EXP_DROP = 3;
`endif

   typedef struct packed {
      logic [7:0] size;
      logic [2:0] pri;
      logic [3:0] dest;
   } alloc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_sop, in_eop;
   logic [63:0] in_data;
   logic        in_ready, wea;
   logic [7:0]  w_size;
   logic [2:0]  pkt_priority;
   logic [3:0]  dest_port;
   logic        writing;
   logic [11:0] write_address;
   logic        sram_we;
   logic [11:0] sram_addr;
   logic [63:0] sram_din;
   logic        pkt_drop, busy;

   int errors = 0;
   int checks = 0;
   int drop_cnt = 0;
   int wea_cnt = 0;
   int we_cnt = 0;
   int d0;

   alloc_t      exp_alloc[$];
   logic [63:0] exp_data[$];
   logic [11:0] exp_addr[$];
   alloc_t      mon_a;

   ingress_buffer #(.MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
      .in_ready(in_ready), .wea(wea), .w_size(w_size), .pkt_priority(pkt_priority),
      .dest_port(dest_port), .writing(writing), .write_address(write_address),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
      .pkt_drop(pkt_drop), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pkt(input int n, input logic [3:0] dest, input logic [2:0] pri,
                           input logic [15:0] tag, input bit keep, input bit with_eop);
      logic [63:0] w;
      alloc_t      a;
      if (keep) begin
         a.size = 8'(n);
         a.pri  = pri;
         a.dest = dest;
         exp_alloc.push_back(a);
      end
      for (int i = 0; i < n; i++) begin
         w = {tag, 8'(i), 32'($urandom), 1'b0, pri, dest};
         @(negedge clk);
         check("in_ready_rx", 64'(in_ready), 64'd1);
         in_valid = 1'b1;
         in_sop   = (i == 0);
         in_eop   = with_eop && (i == n - 1);
         in_data  = w;
         if (keep) exp_data.push_back(w);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_data  = 64'd0;
      check("wea_timing", 64'(wea), 64'(keep));
   endtask

   task automatic grant(input int n, input logic [11:0] base, input bit rel);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("in_ready_busy", 64'(in_ready), 64'd0);
         writing       = 1'b1;
         write_address = base + 12'(i);
         exp_addr.push_back(base + 12'(i));
      end
      if (rel) begin
         @(negedge clk);
         writing       = 1'b0;
         write_address = 12'd0;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_wea"}, 64'(wea), 64'd0);
      check({tag, "_w_size"}, 64'(w_size), 64'd0);
      check({tag, "_priority"}, 64'(pkt_priority), 64'd0);
      check({tag, "_dest"}, 64'(dest_port), 64'd0);
      check({tag, "_sram_we"}, 64'(sram_we), 64'd0);
      check({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
      check({tag, "_sram_din"}, sram_din, 64'd0);
      check({tag, "_pkt_drop"}, 64'(pkt_drop), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT produces output.
   always @(negedge clk) begin
      if (pkt_drop === 1'b1) drop_cnt++;
      if (wea === 1'b1) begin
         wea_cnt++;
         if (exp_alloc.size() == 0) begin
            check("wea_unexpected", 64'(wea), 64'd0);
         end else begin
            mon_a = exp_alloc.pop_front();
            check("w_size", 64'(w_size), 64'(mon_a.size));
            check("priority", 64'(pkt_priority), 64'(mon_a.pri));
            check("dest_port", 64'(dest_port), 64'(mon_a.dest));
         end
      end
      if (sram_we === 1'b1) begin
         we_cnt++;
         if (exp_data.size() == 0 || exp_addr.size() == 0) begin
            check("sram_we_unexpected", 64'(sram_we), 64'd0);
         end else begin
            check("sram_addr", 64'(sram_addr), 64'(exp_addr.pop_front()));
            check("sram_din", sram_din, exp_data.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 64'd0;
      writing = 1'b0; write_address = 12'd0;
      cycles(3);
      check_zero_outputs("reset");
      rst = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // 4-word packet, dest 5, priority 3, written to 0x010..0x013.
      send_pkt(4, 4'd5, 3'd3, 16'hB004, 1'b1, 1'b1);
      grant(4, 12'h010, 1'b1);
      check_idle("pkt4_done");

      // Grant strobes with nothing buffered must not write.
      writing = 1'b1; write_address = 12'h0FF;
      @(negedge clk);
      check("idle_writing_1", 64'(sram_we), 64'd0);
      @(negedge clk);
      writing = 1'b0;
      check("idle_writing_2", 64'(sram_we), 64'd0);

      // Single-word packet.
      send_pkt(1, 4'd9, 3'd7, 16'hC001, 1'b1, 1'b1);
      grant(1, 12'h100, 1'b1);
      check_idle("pkt1_done");

      // Words without SOP in IDLE are discarded.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sop = 1'b0; in_eop = (i == 2); in_data = 64'hDEAD_0000 + 64'(i);
      end
      @(negedge clk);
      in_valid = 1'b0; in_eop = 1'b0;
      check("stray_busy", 64'(busy), 64'd0);
      check("stray_wea", 64'(wea), 64'd0);

      // Exactly MAX_WORDS words is still a legal packet.
      send_pkt(MAXW, 4'hA, 3'd1, 16'hE008, 1'b1, 1'b1);
      grant(MAXW, 12'h300, 1'b1);
      check_idle("pkt_max_done");

      // MAX_WORDS+3 words: dropped once, no allocation.
      d0 = drop_cnt;
      send_pkt(MAXW + 3, 4'h2, 3'd4, 16'hF00B, 1'b0, 1'b1);
      check("oversize_busy", 64'(busy), 64'd0);
      cycles(1);
      check("oversize_drops", 64'(drop_cnt - d0), 64'd1);

      // New SOP after 2 words restarts with the new 3-word packet.
      d0 = drop_cnt;
      send_pkt(2, 4'h1, 3'd2, 16'h6002, 1'b0, 1'b0);
      send_pkt(3, 4'h7, 3'd6, 16'h6003, 1'b1, 1'b1);
      check("restart_drops", 64'(drop_cnt - d0), 64'd1);
      grant(3, 12'h400, 1'b1);
      check_idle("restart_done");

      // Grant stops after 2 of 4 slots.
      d0 = drop_cnt;
      send_pkt(4, 4'h3, 3'd5, 16'h4804, 1'b1, 1'b1);
      grant(2, 12'h500, 1'b1);
      cycles(2);
      check("partial_drops", 64'(drop_cnt - d0), 64'd1);
      check_idle("partial_idle");
      check("partial_left", 64'(exp_data.size()), 64'd2);
      exp_data.delete();

      // No grant for a long time.
      d0 = drop_cnt;
      send_pkt(2, 4'hB, 3'd0, 16'h1902, 1'b1, 1'b1);
`ifdef INGRESS_TIMEOUT_EN
      cycles(TMO + 4);
      check("timeout_drops", 64'(drop_cnt - d0), 64'd1);
      check_idle("timeout_idle");
      check("timeout_left", 64'(exp_data.size()), 64'd2);
      exp_data.delete();
`else
      cycles(40);
      check("wait_busy", 64'(busy), 64'd1);
      check("wait_ready", 64'(in_ready), 64'd0);
      check("wait_drops", 64'(drop_cnt - d0), 64'd0);
      grant(2, 12'h600, 1'b1);
      check_idle("wait_done");
`endif

      // Reset in the middle of a transfer.
      d0 = drop_cnt;
      send_pkt(4, 4'hD, 3'd2, 16'h1A04, 1'b1, 1'b1);
      grant(2, 12'h700, 1'b0);
      @(negedge clk);
      rst = 1'b0; writing = 1'b0; write_address = 12'd0;
      @(negedge clk);
      check_zero_outputs("midxfer_rst");
      check("midxfer_drops", 64'(drop_cnt - d0), 64'd0);
      rst = 1'b1;
      check("midxfer_left", 64'(exp_data.size()), 64'd2);
      exp_data.delete();
      @(negedge clk);
      check("midxfer_ready", 64'(in_ready), 64'd1);

      // Normal packet after the reset.
      send_pkt(3, 4'hE, 3'd7, 16'h1B03, 1'b1, 1'b1);
      grant(3, 12'h7F0, 1'b1);
      check_idle("after_rst_done");

      cycles(2);
      check("total_wea", 64'(wea_cnt), 64'(EXP_WEA));
      check("total_writes", 64'(we_cnt), 64'(EXP_WE));
      check("total_drops", 64'(drop_cnt), 64'(EXP_DROP));
      check("alloc_q_empty", 64'(exp_alloc.size()), 64'd0);
      check("data_q_empty", 64'(exp_data.size()), 64'd0);
      check("addr_q_empty", 64'(exp_addr.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ingress_buffer.md
INGRESS_BUFFER -- requirements
Module: ingress_buffer

Interface
REQ-001 Parameter MAX_WORDS, default 255: maximum packet length in 64-bit words, range 1..255.
REQ-002 Parameter TIMEOUT, default 16: grant-wait limit in cycles, used only when INGRESS_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  input word valid.
REQ-006 in_sop  input  1  first word of packet; header in in_data[3:0]=dest_port, in_data[6:4]=priority.
REQ-007 in_eop  input  1  last word of packet.
REQ-008 in_data  input  64  packet word; the header word is stored as word 0.
REQ-009 in_ready  output  1  word accepted when in_valid&&in_ready.
REQ-010 wea  output  1  one-cycle allocation request to the chain manager.
REQ-011 w_size  output  8  packet length in words, valid while wea=1.
REQ-012 priority  output  3  packet priority, valid while wea=1.
REQ-013 dest_port  output  4  packet destination port, valid while wea=1.
REQ-014 writing  input  1  chain manager address-valid strobe; one word slot per cycle high.
REQ-015 write_address  input  12  SRAM word address for the current slot.
REQ-016 sram_we  output  1  SRAM write strobe.
REQ-017 sram_addr  output  12  SRAM write address.
REQ-018 sram_din  output  64  SRAM write data.
REQ-019 pkt_drop  output  1  one-cycle pulse when a packet is discarded.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states SHALL be IDLE, RECV, REQ, WAIT, XFER and DROP; the block is store-and-forward with one packet buffered at a time.
REQ-022 in_ready SHALL be 1 in IDLE, RECV and DROP, and 0 in REQ, WAIT and XFER.
REQ-023 IDLE: an accepted word with in_sop=1 SHALL be written to buf[0], latch header fields, set cnt=1 and go to RECV; if it also has in_eop=1, go to REQ instead; accepted words without in_sop SHALL be discarded silently.
REQ-024 RECV: each accepted word SHALL be written to buf[cnt] and cnt incremented; on in_eop the FSM goes to REQ.
REQ-025 RECV: an accepted word with in_sop=1 SHALL pulse pkt_drop, discard the current packet, and restart reception with that word as word 0.
REQ-026 RECV: once cnt=MAX_WORDS and the accepted word lacks in_eop, the FSM SHALL go to DROP, pulse pkt_drop, and discard input until the in_eop word, then return to IDLE.
REQ-027 REQ: wea SHALL be 1 for exactly one cycle, the cycle after EOP acceptance, with w_size=cnt; the FSM then goes to WAIT.
REQ-028 WAIT/XFER: every cycle with writing=1 SHALL register, one cycle later, sram_we=1, sram_addr=write_address and sram_din=buf[rd_idx], then increment rd_idx; the first such cycle moves WAIT to XFER.
REQ-029 When rd_idx reaches w_size, the FSM SHALL return to IDLE; further writing cycles SHALL be ignored with sram_we=0.
REQ-030 XFER: writing=0 before rd_idx reaches w_size SHALL pulse pkt_drop and return to IDLE.
REQ-031 cnt and rd_idx SHALL be 8-bit and never wrap; the buffer SHALL be MAX_WORDS x 64 bits.
REQ-032 A packet SHALL become accepted input again one cycle after its last SRAM write.

Reset
REQ-033 With rst=0 at a posedge: FSM to IDLE, cnt=rd_idx=0, and wea, w_size, priority, dest_port, sram_we, sram_addr, sram_din, pkt_drop and busy all 0; in_ready=1 from the first cycle after release.
REQ-034 Reset in any state SHALL abandon the buffered packet with no pkt_drop pulse; buffer contents are don't-care.

Configuration
REQ-035 INGRESS_TIMEOUT_EN defined: TIMEOUT consecutive cycles in WAIT with writing=0 SHALL pulse pkt_drop and return to IDLE; undefined: WAIT persists until writing=1.

Verification
REQ-036 4-word packet, header dest=5, pri=3 -> wea pulse with w_size=4, priority=3, dest_port=5; writing high 4 cycles at addr 0x010.. -> sram_we 4 cycles at 0x010..0x013 carrying words 0..3 in order.
REQ-037 Single word with sop and eop -> wea with w_size=1 the next cycle; one SRAM write.
REQ-038 MAX_WORDS+3 words -> pkt_drop once, no wea, in_ready=1 throughout, IDLE after eop.
REQ-039 New sop after 2 words of a packet -> pkt_drop; the new 3-word packet produces wea with w_size=3.
REQ-040 writing drops after 2 of 4 slots -> 2 SRAM writes, pkt_drop, IDLE; with INGRESS_TIMEOUT_EN and TIMEOUT=16, no writing for 16 cycles -> pkt_drop on cycle 16.
REQ-041 rst=0 mid-XFER -> all outputs 0 next cycle, no pkt_drop, next packet handled normally.
